switch_step_sequencer: RTL and testbench

SWITCH_STEP_SEQUENCER -- requirements
Module: switch_step_sequencer

---
 rtl/switch_step_sequencer.sv | 175 +++++++++++++++++
 tb/tb_switch_step_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_step_sequencer.sv
// switch_step_sequencer
//   Debounces four raw coin/key switches and turns each clean, single-switch
//   press into exactly one step handed to a downstream state machine with a
//   valid/ready handshake. Multi-switch presses are rejected with a pulse.
//
//   Optional feature macro: STEP_ERR_CNT_EN adds the saturating err_count
//   port and its register.
//
// Ports
//   CLOCK_50    in   1  system clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   sw          in   4  raw asynchronous switches, active-high
//   step_ready  in   1  downstream accepts the step this cycle
//   step_valid  out  1  step_code holds a qualified press
//   step_code   out  2  index of the pressed switch
//   step_count  out  8  accepted steps since reset, wrapping
//   busy        out  1  FSM is not idle
//   err_multi   out  1  one-cycle pulse on a rejected multi-switch press
//   err_count   out  8  rejected presses, saturating (STEP_ERR_CNT_EN only)
module switch_step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_code,
    output logic [7:0] step_count,
    output logic       busy,
    output logic       err_multi
`ifdef STEP_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        ISSUE,
        WAIT_REL,
        DB_REL
    } state_t;

    state_t           state, state_d;
    logic [3:0]       sw_m, sw_s;
    logic [3:0]       sample, sample_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_d;
    logic             accept;
    logic             one_hot;

    function automatic logic [1:0] encode(input logic [3:0] v);
        logic [1:0] c;
        c = 2'd0;
        if (v[1]) c = 2'd1;
        if (v[2]) c = 2'd2;
        if (v[3]) c = 2'd3;
        return c;
    endfunction

    assign one_hot = (sample != 4'd0) && ((sample & (sample - 4'd1)) == 4'd0);

    // Two-flop synchronizer; only sw_s is ever looked at by the FSM.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sw_m <= 4'd0;
            sw_s <= 4'd0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sample <= 4'd0;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            sample <= sample_d;
            cnt    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        sample_d = sample;
        cnt_d    = cnt;
        err_d    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (sw_s != 4'd0) begin
                    sample_d = sw_s;
                    cnt_d    = '0;
                    state_d  = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (sw_s != sample) begin
                    state_d = IDLE;
                end else if (cnt == CNT_MAX) begin
                    if (one_hot) begin
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_REL;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            // Switch activity is deliberately ignored here so the offered
            // step cannot be withdrawn before the consumer takes it.
            ISSUE: begin
                if (step_ready) begin
                    accept  = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (sw_s == 4'd0) begin
                    cnt_d   = '0;
                    state_d = DB_REL;
                end
            end
            DB_REL: begin
                if (sw_s != 4'd0) begin
                    state_d = WAIT_REL;
                end else if (cnt == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are flops loaded from the next state, so they line up with the
    // state register and have no combinational path from sw or step_ready.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            step_valid <= 1'b0;
            step_code  <= 2'd0;
            step_count <= 8'd0;
            busy       <= 1'b0;
            err_multi  <= 1'b0;
        end else begin
            step_valid <= (state_d == ISSUE);
            busy       <= (state_d != IDLE);
            err_multi  <= err_d;
            if (state == DB_PRESS && state_d == ISSUE)
                step_code <= encode(sample);
            if (accept)
                step_count <= step_count + 8'd1;
        end
    end

`ifdef STEP_ERR_CNT_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            err_count <= 8'd0;
        else if (err_d && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_switch_step_sequencer.sv
module tb_switch_step_sequencer;

    localparam int DB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic [3:0] sw       = 4'd0;
    logic       step_ready = 1'b0;
    logic       step_valid;
    logic [1:0] step_code;
    logic [7:0] step_count;
    logic       busy;
    logic       err_multi;
`ifdef STEP_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    switch_step_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .sw         (sw),
        .step_ready (step_ready),
        .step_valid (step_valid),
        .step_code  (step_code),
        .step_count (step_count),
        .busy       (busy),
        .err_multi  (err_multi)
`ifdef STEP_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: expected step codes in press order; model step counter.
    logic [1:0] sb_q[$];
    logic [7:0] mdl_cnt  = 8'd0;
    int         n_acc    = 0;
    int         n_err    = 0;
    logic       cnt_due  = 1'b0;
    logic       prev_vld = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [1:0] prev_code = 2'd0;

    always @(negedge CLOCK_50) begin
        if (!reset_n) begin
            sb_q.delete();
            mdl_cnt  = 8'd0;
            n_err    = 0;
            cnt_due  = 1'b0;
            prev_vld = 1'b0;
        end else begin
            if (cnt_due) begin
                chk("step_count", step_count, mdl_cnt);
                cnt_due = 1'b0;
            end
            if (prev_vld && !prev_rdy) begin
                chk("hold_valid", step_valid, 1);
                chk("hold_code", step_code, prev_code);
            end
            if (err_multi) n_err++;
            if (step_valid && step_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_step", sb_q.size(), 1);
                end else begin
                    chk("step_code", step_code, sb_q.pop_front());
                    mdl_cnt = mdl_cnt + 8'd1;
                    n_acc++;
                    cnt_due = 1'b1;
                end
            end
            prev_vld  = step_valid;
            prev_rdy  = step_ready;
            prev_code = step_code;
        end
    end

    // Counts rising edges from the call until step_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLOCK_50);
            n++;
            @(negedge CLOCK_50);
            if (step_valid) break;
        end
        chk("valid_seen", step_valid, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int err0;
        int acc0;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_valid", step_valid, 0);
        chk("rst_code", step_code, 0);
        chk("rst_count", step_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_multi, 0);
        @(posedge CLOCK_50); #1 reset_n = 1'b1;
        repeat (3) @(posedge CLOCK_50);

        // Clean press of sw[1] with ready high: latency and single step
        #1 sw = 4'b0010; step_ready = 1'b1; sb_q.push_back(2'd1);
        wait_valid(lat);
        chk("latency", lat, DB + 3);
        repeat (20) @(posedge CLOCK_50);
        #1 sw = 4'b0000;
        repeat (20) @(posedge CLOCK_50);
        chk("one_step", n_acc, 1);

        // Glitching sw[2]: never qualifies, FSM drops to idle each glitch
        for (int i = 0; i < 5; i++) begin
            #1 sw = 4'b0100;
            @(posedge CLOCK_50);
            if (i > 0) begin
                @(negedge CLOCK_50);
                chk("glitch_idle", busy, 0);
            end
            repeat (2) @(posedge CLOCK_50);
            #1 sw = 4'b0000;
            repeat (2) @(posedge CLOCK_50);
        end
        repeat (20) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("glitch_steps", n_acc, 1);
        chk("glitch_busy", busy, 0);

        // Multi-switch press: one error pulse, no step
        @(posedge CLOCK_50);
        err0 = n_err;
        #1 sw = 4'b1001;
        repeat (15) @(posedge CLOCK_50);
        #1 sw = 4'b0000;
        repeat (15) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("err_pulses", n_err - err0, 1);
        chk("err_no_step", n_acc, 1);
`ifdef STEP_ERR_CNT_EN
        chk("err_count", err_count, n_err);
`endif

        // Backpressure: step held until ready, even after switch release
        @(posedge CLOCK_50);
        #1 step_ready = 1'b0; sw = 4'b1000; sb_q.push_back(2'd3);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50);
            if (i == 3) #1 sw = 4'b0000;
        end
        @(negedge CLOCK_50);
        chk("bp_valid", step_valid, 1);
        chk("bp_code", step_code, 3);
        chk("bp_count", step_count, mdl_cnt);
        @(posedge CLOCK_50); #1 step_ready = 1'b1;
        @(posedge CLOCK_50); #1 step_ready = 1'b0;
        @(negedge CLOCK_50);
        chk("bp_drop", step_valid, 0);
        repeat (20) @(posedge CLOCK_50);
        chk("bp_steps", n_acc, 2);

        // Fresh reset, then 256 presses of sw[0] with release bounce
        #1 reset_n = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 reset_n = 1'b1; step_ready = 1'b1;
        acc0 = n_acc;
        for (int p = 0; p < 256; p++) begin
            @(posedge CLOCK_50);
            #1 sw = 4'b0001; sb_q.push_back(2'd0);
            repeat (12) @(posedge CLOCK_50);
            #1 sw = 4'b0000;
            repeat (2) @(posedge CLOCK_50);
            #1 sw = 4'b0001;
            repeat (2) @(posedge CLOCK_50);
            #1 sw = 4'b0000;
            @(posedge CLOCK_50);
            #1 sw = 4'b0001;
            @(posedge CLOCK_50);
            #1 sw = 4'b0000;
            repeat (10) @(posedge CLOCK_50);
            if (p == 254) begin
                @(negedge CLOCK_50);
                chk("count_255", step_count, 255);
            end
        end
        @(negedge CLOCK_50);
        chk("count_wrap", step_count, 0);
        chk("wrap_steps", n_acc - acc0, 256);

        // Reset during ISSUE discards the step; held switch re-debounced
        @(posedge CLOCK_50);
        #1 step_ready = 1'b0; sw = 4'b0100; sb_q.push_back(2'd2);
        wait_valid(lat);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_issue_valid", step_valid, 0);
        chk("rst_issue_count", step_count, 0);
        chk("rst_issue_busy", busy, 0);
        repeat (3) @(posedge CLOCK_50);
        #1 reset_n = 1'b1; step_ready = 1'b1; sb_q.push_back(2'd2);
        acc0 = n_acc;
        wait_valid(lat);
        chk("rst_relatency", lat, DB + 3);
        #1 sw = 4'b0000;
        repeat (20) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_step", n_acc - acc0, 1);
        chk("rst_final_count", step_count, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
